// File: rtl/pixel_centroid_accum_pkg.sv
// Shared types and defaults for the pixel centroid accumulator.
package pixel_centroid_accum_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACCUM    = 1'b1
    } state_t;

    // Index width for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_xy_counter.sv
// Raster x/y position of the current pixel plus a last-pixel-of-frame flag.
// clear_i zeroes the position combinationally so a pixel on the same cycle is (0,0).
module pixel_xy_counter
    import pixel_centroid_accum_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int XW       = idx_w(H_ACTIVE),
    parameter int YW       = idx_w(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_o    = clear_i ? '0 : x_q;
        y_o    = clear_i ? '0 : y_q;
        last_o = (x_o == X_MAX) && (y_o == Y_MAX);
        x_d    = x_o;
        y_d    = y_o;
        if (advance_i) begin
            if (x_o == X_MAX) begin
                x_d = '0;
                y_d = (y_o == Y_MAX) ? '0 : y_o + 1'b1;
            end else begin
                x_d = x_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/pixel_centroid_accum.sv
// Per-frame sums of x, y and count of pixels at or above a threshold, for centroid division.
// Result is valid 2 edges after the last pixel and held until res_valid && res_ready.
module pixel_centroid_accum
    import pixel_centroid_accum_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int SUM_W    = 32,
    parameter int CNT_W    = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             pix_valid,
    input  logic [7:0]       pix_data,
    input  logic [7:0]       threshold,
    output logic [SUM_W-1:0] sum_x,
    output logic [SUM_W-1:0] sum_y,
    output logic [CNT_W-1:0] hit_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_empty,
    output logic             overrun
);

    localparam int XW = idx_w(H_ACTIVE);
    localparam int YW = idx_w(V_ACTIVE);

    state_t           state_q, state_d;
    logic [7:0]       thr_q;
    logic [SUM_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [CNT_W-1:0] acc_n_q, acc_n_d;
    logic             done_q;
    logic [SUM_W-1:0] sum_x_q, sum_y_q;
    logic [CNT_W-1:0] hit_count_q;
    logic             res_valid_q, res_empty_q, overrun_q;

    logic             accept, hit, frame_done, last_pix;
    logic [7:0]       thr_eff;
    logic [XW-1:0]    x_cur;
    logic [YW-1:0]    y_cur;

    pixel_xy_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_xy (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (sof),
        .advance_i (accept),
        .x_o       (x_cur),
        .y_o       (y_cur),
        .last_o    (last_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_SOF;
        else     state_q <= state_d;
    end

    // A sof always (re)starts a frame; a pixel on the sof cycle belongs to it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_SOF: if (sof && !frame_done) state_d = ACCUM;
            ACCUM:    if (frame_done)         state_d = WAIT_SOF;
        endcase
    end

    always_comb begin
        accept     = pix_valid && ((state_q == ACCUM) || sof);
        thr_eff    = sof ? threshold : thr_q;
        hit        = accept && (pix_data >= thr_eff);
        frame_done = accept && last_pix;
    end

    always_comb begin
        acc_x_d = (sof ? '0 : acc_x_q) + (hit ? SUM_W'(x_cur) : '0);
        acc_y_d = (sof ? '0 : acc_y_q) + (hit ? SUM_W'(y_cur) : '0);
        acc_n_d = (sof ? '0 : acc_n_q) + CNT_W'(hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q   <= '0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            acc_n_q <= '0;
            done_q  <= 1'b0;
        end else begin
            if (sof) thr_q <= threshold;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            acc_n_q <= acc_n_d;
            done_q  <= frame_done;
        end
    end

    // A fresh result beats a same-cycle consume; overrun only if the old one was never taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            hit_count_q <= '0;
            res_valid_q <= 1'b0;
            res_empty_q <= 1'b1;
            overrun_q   <= 1'b0;
        end else if (done_q) begin
            sum_x_q     <= acc_x_q;
            sum_y_q     <= acc_y_q;
            hit_count_q <= acc_n_q;
            res_empty_q <= (acc_n_q == '0);
            res_valid_q <= 1'b1;
            if (res_valid_q && !res_ready) overrun_q <= 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign sum_x     = sum_x_q;
    assign sum_y     = sum_y_q;
    assign hit_count = hit_count_q;
    assign res_valid = res_valid_q;
    assign res_empty = res_empty_q;
    assign overrun   = overrun_q;

endmodule
